// File: rtl/reset_sequencer.sv
// Staged reset controller: holds all domains, then releases per-block resets in ascending order.
// Optional watchdog-triggered re-sequencing is compiled in with RESET_SEQ_WDOG_EN.
module reset_sequencer #(
    parameter int unsigned N_STAGES    = 4,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned STAGE_GAP   = 8,
    parameter int unsigned CNT_W       = 8
`ifdef RESET_SEQ_WDOG_EN
    ,
    parameter int unsigned WDOG_CYCLES = 200
`endif
) (
    input  logic                clk,
    input  logic                as_rst,
    input  logic                sw_rst_req,
    output logic                sw_rst_ack,
    output logic [N_STAGES-1:0] stage_rst_n,
    output logic                busy,
    output logic                ready
`ifdef RESET_SEQ_WDOG_EN
    ,
    input  logic                wdog_kick,
    output logic                wdog_expired
`endif
);

    localparam int unsigned IDX_W = $clog2(N_STAGES + 1);

    localparam logic [1:0] S_HOLD  = 2'd0;
    localparam logic [1:0] S_STAGE = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_ACK   = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                pending_q, pending_d;
    logic [N_STAGES-1:0] stage_d;
    logic                ack_d;
    logic                busy_d;
    logic                restart;
`ifdef RESET_SEQ_WDOG_EN
    logic [CNT_W-1:0]    wdog_cnt_q, wdog_cnt_d;
    logic                expired_d;
    logic                wdog_fire;
`endif

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        stage_d   = stage_rst_n;
        ack_d     = sw_rst_ack;
        restart   = 1'b0;
`ifdef RESET_SEQ_WDOG_EN
        expired_d  = wdog_expired;
        wdog_fire  = (state_q == S_RUN) && !sw_rst_req && !wdog_kick &&
                     (wdog_cnt_q == CNT_W'(WDOG_CYCLES - 1));
        wdog_cnt_d = '0;
        if (state_q == S_RUN && !wdog_kick)
            wdog_cnt_d = wdog_cnt_q + CNT_W'(1);
`endif

        case (state_q)
            S_HOLD: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                    stage_d[0] = 1'b1;
                    cnt_d      = '0;
                    idx_d      = IDX_W'(1);
                    state_d    = S_STAGE;
                end
            end
            S_STAGE: begin
                // One settling cycle after the last release before reporting ready.
                if (idx_q == IDX_W'(N_STAGES)) begin
                    state_d = pending_q ? S_ACK : S_RUN;
                    ack_d   = pending_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
                        for (int unsigned i = 0; i < N_STAGES; i++) begin
                            if (idx_q == IDX_W'(i))
                                stage_d[i] = 1'b1;
                        end
                        cnt_d = '0;
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_RUN: begin
                if (sw_rst_req) begin
                    restart   = 1'b1;
                    pending_d = 1'b1;
                end
`ifdef RESET_SEQ_WDOG_EN
                else if (wdog_fire) begin
                    restart   = 1'b1;
                    expired_d = 1'b1;
                end
`endif
            end
            S_ACK: begin
                if (!sw_rst_req) begin
                    ack_d     = 1'b0;
                    pending_d = 1'b0;
                    state_d   = S_RUN;
`ifdef RESET_SEQ_WDOG_EN
                    expired_d = 1'b0;
`endif
                end
            end
            default: state_d = S_HOLD;
        endcase

        if (restart) begin
            stage_d = '0;
            cnt_d   = '0;
            idx_d   = '0;
            state_d = S_HOLD;
`ifdef RESET_SEQ_WDOG_EN
            wdog_cnt_d = '0;
`endif
        end

        busy_d = (state_d == S_HOLD) || (state_d == S_STAGE);
    end

    always_ff @(posedge clk or posedge as_rst) begin
        if (as_rst) begin
            state_q     <= S_HOLD;
            cnt_q       <= '0;
            idx_q       <= '0;
            pending_q   <= 1'b0;
            stage_rst_n <= '0;
            sw_rst_ack  <= 1'b0;
            busy        <= 1'b1;
            ready       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pending_q   <= pending_d;
            stage_rst_n <= stage_d;
            sw_rst_ack  <= ack_d;
            busy        <= busy_d;
            ready       <= !busy_d;
        end
    end

`ifdef RESET_SEQ_WDOG_EN
    always_ff @(posedge clk or posedge as_rst) begin
        if (as_rst) begin
            wdog_cnt_q   <= '0;
            wdog_expired <= 1'b0;
        end else begin
            wdog_cnt_q   <= wdog_cnt_d;
            wdog_expired <= expired_d;
        end
    end
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: expected output changes are queued by stimulus,
// a negedge monitor pops one entry per observed output change and compares cycle and value.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       as_rst;
    logic       sw_rst_req;
    logic       sw_rst_ack;
    logic [3:0] stage_rst_n;
    logic       busy;
    logic       ready;
    logic       wdog_kick;
    logic       wdog_exp_v;

    logic       as_rst_c;
    logic       ack_c;
    logic [0:0] stage_c;
    logic       busy_c;
    logic       ready_c;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } exp_t;

    exp_t       exp_q[$];
    logic       mon_en = 1'b0;
    logic [7:0] prev_obs;
    logic [7:0] obs;

    localparam logic [7:0] RST_VAL = 8'b0001_0000;
    localparam int         FAR     = 1 << 30;

`ifdef RESET_SEQ_WDOG_EN
    logic wdog_kick_c;
    logic wdog_exp_c;
    assign wdog_kick_c = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    reset_sequencer u_dut (
        .clk         (clk),
        .as_rst      (as_rst),
        .sw_rst_req  (sw_rst_req),
        .sw_rst_ack  (sw_rst_ack),
        .stage_rst_n (stage_rst_n),
        .busy        (busy),
        .ready       (ready)
`ifdef RESET_SEQ_WDOG_EN
        ,
        .wdog_kick   (wdog_kick),
        .wdog_expired(wdog_exp_v)
`endif
    );

    reset_sequencer #(.N_STAGES(1), .HOLD_CYCLES(1)) u_corner (
        .clk         (clk),
        .as_rst      (as_rst_c),
        .sw_rst_req  (1'b0),
        .sw_rst_ack  (ack_c),
        .stage_rst_n (stage_c),
        .busy        (busy_c),
        .ready       (ready_c)
`ifdef RESET_SEQ_WDOG_EN
        ,
        .wdog_kick   (wdog_kick_c),
        .wdog_expired(wdog_exp_c)
`endif
    );

`ifndef RESET_SEQ_WDOG_EN
    assign wdog_exp_v = 1'b0;
`endif

    assign obs = {wdog_exp_v, sw_rst_ack, ready, busy, stage_rst_n};

    // Monitor: each change of the observed outputs consumes one expected entry.
    always @(negedge clk) begin
        if (mon_en && obs !== prev_obs) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_change cyc=%0d got=%b", edge_n, obs);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.cyc != edge_n || e.val !== obs) begin
                    failures++;
                    $display("FAIL scoreboard got cyc=%0d val=%b required cyc=%0d val=%b",
                             edge_n, obs, e.cyc, e.val);
                end
            end
        end
        prev_obs <= obs;
    end

    function automatic void push(input int cyc, input logic [7:0] val);
        exp_t e;
        e.cyc = cyc;
        e.val = val;
        exp_q.push_back(e);
    endfunction

    // Release schedule with defaults HOLD=16, GAP=8, N=4, counted from edge s.
    task automatic push_sched(input int s, input logic ack, input logic ex, input int lim);
        if (s + 16 <= lim) push(s + 16, {ex, 3'b001, 4'b0001});
        if (s + 24 <= lim) push(s + 24, {ex, 3'b001, 4'b0011});
        if (s + 32 <= lim) push(s + 32, {ex, 3'b001, 4'b0111});
        if (s + 40 <= lim) push(s + 40, {ex, 3'b001, 4'b1111});
        if (s + 41 <= lim) push(s + 41, {ex, ack, 2'b10, 4'b1111});
    endtask

    task automatic wait_until(input int e);
        while (edge_n < e) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%b required=%b", name, got, req);
        end
    endtask

    task automatic do_reset(input logic req, output int base);
        @(posedge clk);
        #1;
        as_rst     = 1'b1;
        sw_rst_req = req;
        push(edge_n, RST_VAL);
        repeat (3) @(negedge clk);
        as_rst = 1'b0;
        base   = edge_n;
    endtask

    initial begin
        int base;
        int s;
        int u;
        as_rst     = 1'b1;
        as_rst_c   = 1'b1;
        sw_rst_req = 1'b0;
        wdog_kick  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", obs, RST_VAL);
        check("corner_reset_state", {5'b0, stage_c, busy_c, ready_c}, 8'b0000_0010);

        // Power-on sequence.
        mon_en = 1'b1;
        as_rst = 1'b0;
        base   = edge_n;
        push_sched(base, 1'b0, 1'b0, FAR);
        wait_until(base + 45);

        // Software reset with four-phase handshake.
        sw_rst_req = 1'b1;
        s = edge_n + 1;
        push(s, RST_VAL);
        push_sched(s, 1'b1, 1'b0, FAR);
        wait_until(s + 44);
        sw_rst_req = 1'b0;
        u = edge_n + 1;
        push(u, 8'b0010_1111);
        wait_until(u + 3);

        // Abort at edge 28 of a sequence, then a full schedule again.
        do_reset(1'b0, base);
        push_sched(base, 1'b0, 1'b0, base + 28);
        wait_until(base + 27);
        @(posedge clk);
        #1;
        as_rst = 1'b1;
        push(edge_n, RST_VAL);
        repeat (2) @(negedge clk);
        as_rst = 1'b0;
        base   = edge_n;
        push_sched(base, 1'b0, 1'b0, FAR);
        wait_until(base + 45);

        // Request held from reset: one extra sequence starting at edge 42.
        do_reset(1'b1, base);
        push_sched(base, 1'b0, 1'b0, FAR);
        s = base + 42;
        push(s, RST_VAL);
        push_sched(s, 1'b1, 1'b0, FAR);
        wait_until(s + 44);
        sw_rst_req = 1'b0;
        u = edge_n + 1;
        push(u, 8'b0010_1111);
        wait_until(u + 3);

`ifdef RESET_SEQ_WDOG_EN
        // Watchdog fires 200 cycles into RUN, stays sticky through kicks, clears on ACK exit.
        do_reset(1'b0, base);
        push_sched(base, 1'b0, 1'b0, FAR);
        s = base + 241;
        push(s, 8'b1001_0000);
        push_sched(s, 1'b0, 1'b1, FAR);
        wait_until(s + 44);
        for (int k = 0; k < 5; k++) begin
            repeat (99) @(negedge clk);
            wdog_kick = 1'b1;
            @(negedge clk);
            wdog_kick = 1'b0;
        end
        sw_rst_req = 1'b1;
        s = edge_n + 1;
        push(s, 8'b1001_0000);
        push_sched(s, 1'b1, 1'b1, FAR);
        wait_until(s + 44);
        sw_rst_req = 1'b0;
        u = edge_n + 1;
        push(u, 8'b0010_1111);
        wait_until(u + 3);
`endif

        check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
        mon_en = 1'b0;

        // N_STAGES=1, HOLD_CYCLES=1: release after edge 1, ready after edge 2.
        as_rst_c = 1'b0;
        @(negedge clk);
        check("corner_edge1", {5'b0, stage_c, busy_c, ready_c}, 8'b0000_0110);
        @(negedge clk);
        check("corner_edge2", {5'b0, stage_c, busy_c, ready_c}, 8'b0000_0101);
        check("corner_ack", {7'b0, ack_c}, 8'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
